// File: rtl/fp16_add_arbiter_pkg.sv
// Shared definitions for the FP16 adder arbiter: FSM states, FP16 width and
// operation encodings.
package fp16_add_arbiter_pkg;

   localparam int FP_W = 16;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } stateT;

endpackage

// File: rtl/fp16_add_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one above ptr and
// wraps, so the last winner has lowest priority next time.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gntIdx
);

   // First requester at or after ptr+1 (modulo N) wins.
   always_comb begin
      int   cand;
      logic found;
      gnt    = '0;
      gntIdx = '0;
      found  = 1'b0;
      cand   = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gntIdx    = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/fpa.sv
// Shared combinational half-precision adder/subtractor.
// Round-to-nearest-even, gradual underflow, overflow to infinity,
// canonical quiet NaN (16'h7E00) for any NaN input or inf - inf.
module FPA (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        addOrSub,
   output logic [15:0] result
);

   logic [15:0] bEff, x, y;
   logic [4:0]  expX, expY, shiftAmt;
   logic [5:0]  expR;
   logic [10:0] manX, manY;
   logic [13:0] yFull, alignY;
   logic [14:0] sum, packedMag;
   logic        effSub, roundUp;
   logic        aNan, bNan, aInf, bInf;

   // Align, add/subtract, normalise and round; specials override at the end.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      bEff      = {b[15] ^ addOrSub, b[14:0]};
      x         = a;
      y         = bEff;
      if (a[14:0] < bEff[14:0]) begin
         x = bEff;
         y = a;
      end
      effSub    = x[15] ^ y[15];
      expX      = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
      expY      = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
      manX      = {x[14:10] != 5'd0, x[9:0]};
      manY      = {y[14:10] != 5'd0, y[9:0]};
      shiftAmt  = expX - expY;
      yFull     = {manY, 3'b000};
      if (shiftAmt >= 5'd14) begin
         alignY = {13'd0, |manY};
      end else begin
         alignY = (yFull >> shiftAmt) | {13'd0, |(yFull & ~(14'h3FFF << shiftAmt))};
      end
      sum       = effSub ? ({1'b0, manX, 3'b000} - {1'b0, alignY})
                         : ({1'b0, manX, 3'b000} + {1'b0, alignY});
      expR      = {1'b0, expX};
      if (sum[14]) begin
         sum  = {1'b0, sum[14:2], sum[1] | sum[0]};
         expR = expR + 6'd1;
      end else begin
         for (int i = 0; i < 13; i++) begin
            if (!sum[13] && (expR > 6'd1)) begin
               sum  = sum << 1;
               expR = expR - 6'd1;
            end
         end
      end
      roundUp   = sum[2] & (sum[3] | sum[1] | sum[0]);
      // A mantissa carry from rounding ripples into the exponent field.
      packedMag = {(sum[13] ? expR[4:0] : 5'd0), sum[12:3]} + {14'd0, roundUp};

      aNan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      bNan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
      aInf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
      bInf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);

      if (aNan || bNan) begin
         result = 16'h7E00;
      end else if (aInf && bInf) begin
         result = (a[15] != bEff[15]) ? 16'h7E00 : {a[15], 15'h7C00};
      end else if (aInf) begin
         result = a;
      end else if (bInf) begin
         result = bEff;
      end else if (sum == 15'd0) begin
         result = {effSub ? 1'b0 : x[15], 15'd0};
      end else if (expR >= 6'd31) begin
         result = {x[15], 15'h7C00};
      end else begin
         result = {x[15], packedMag};
      end
   end

endmodule

// File: rtl/fp16_add_arbiter.sv
// Shares one FPA among NUM_REQ requesters. Operands are registered in front of
// the adder and the result behind it; one transaction is in flight at a time.
module fp16_add_arbiter
   import fp16_add_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [FP_W*NUM_REQ-1:0] req_a,
   input  logic [FP_W*NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0]      req_op,
   output logic [NUM_REQ-1:0]      resp_valid,
   input  logic [NUM_REQ-1:0]      resp_ready,
   output logic [FP_W-1:0]         resp_data,
   output logic                    busy,
   output logic [CNT_W-1:0]        op_count
);

   localparam int IDX_W = $clog2(NUM_REQ);

   stateT            state, nextState;
   logic [IDX_W-1:0] ptr, gntQ, arbIdx;
   logic [NUM_REQ-1:0] arbGnt;
   logic [FP_W-1:0]  opA, opB, fpaResult;
   logic             opSub;
   logic             reqFire, respFire;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) uArb (
      .req    (req_valid),
      .ptr    (ptr),
      .gnt    (arbGnt),
      .gntIdx (arbIdx)
   );

   FPA uFpa (
      .a        (opA),
      .b        (opB),
      .addOrSub (opSub == OP_SUB),
      .result   (fpaResult)
   );

   // State register.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // Next state and the handshake outputs derived from the current state.
   always_comb begin
      nextState  = state;
      req_ready  = '0;
      resp_valid = '0;
      reqFire    = 1'b0;
      respFire   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = arbGnt;
            reqFire   = |req_valid;
            if (reqFire) nextState = EXEC;
         end
         EXEC: nextState = RESP;
         RESP: begin
            resp_valid[gntQ] = 1'b1;
            respFire         = resp_ready[gntQ];
            if (respFire) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Operand capture, result latch, grant bookkeeping and completion counter.
   // NOTE: the datapath registers are reset too, so an aborted transaction leaves
   // nothing behind and the adder never sees X after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA       <= '0;
         opB       <= '0;
         opSub     <= OP_ADD;
         gntQ      <= '0;
         ptr       <= IDX_W'(NUM_REQ - 1);
         resp_data <= '0;
         op_count  <= '0;
      end else begin
         if (reqFire) begin
            opA   <= req_a[int'(arbIdx)*FP_W +: FP_W];
            opB   <= req_b[int'(arbIdx)*FP_W +: FP_W];
            opSub <= req_op[arbIdx];
            gntQ  <= arbIdx;
            ptr   <= arbIdx;
         end
         if (state == EXEC) resp_data <= fpaResult;
         if (respFire)      op_count  <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Self-checking bench for fp16_add_arbiter: a transaction-level model checks
// every output on every falling edge; directed scenarios add literal checks.
module tb_fp16_add_arbiter;

   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 4;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [16*NUM_REQ-1:0] req_a = '0;
   logic [16*NUM_REQ-1:0] req_b = '0;
   logic [NUM_REQ-1:0]    req_op = '0;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [NUM_REQ-1:0]    resp_ready = '0;
   logic [15:0]           resp_data;
   logic                  busy;
   logic [CNT_W-1:0]      op_count;

   always #5 clk = ~clk;

   fp16_add_arbiter #(
      .NUM_REQ (NUM_REQ),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy),
      .op_count   (op_count)
   );

   // Standalone adder giving the expected arithmetic result for captured operands.
   logic [15:0] mA = '0, mB = '0, refY;
   logic        mOp = 1'b0;
   FPA refFpa (.a(mA), .b(mB), .addOrSub(mOp), .result(refY));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit          inFlight = 1'b0;
   int          gntM = 0, age = 0, lastGnt = NUM_REQ - 1, count = 0, cycle = 0;
   logic [15:0] expData = '0;
   int          grants[$];
   int          grantCycle[$];

   function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic logic [NUM_REQ-1:0] oneHot(input int i);
      logic [NUM_REQ-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   always @(negedge clk) begin : model
      int g;
      cycle++;
      if (!rst_n) begin
         check("rst_req_ready", req_ready, '0);
         check("rst_resp_valid", resp_valid, '0);
         check("rst_resp_data", resp_data, '0);
         check("rst_busy", busy, 0);
         check("rst_op_count", op_count, '0);
         inFlight = 1'b0;
         age      = 0;
         lastGnt  = NUM_REQ - 1;
         count    = 0;
      end else begin
         g = inFlight ? -1 : pick(req_valid, lastGnt);
         check("req_ready", req_ready, oneHot(g));
         check("busy", busy, inFlight);
         check("resp_valid", resp_valid, (inFlight && age >= 2) ? oneHot(gntM) : '0);
         if (inFlight && age >= 2) check("resp_data", resp_data, expData);
         check("op_count", op_count, count);
         // Advance the model to what the coming clock edge should produce.
         if (!inFlight) begin
            if (g >= 0) begin
               inFlight = 1'b1;
               age      = 1;
               gntM     = g;
               lastGnt  = g;
               mA       = req_a[16*g +: 16];
               mB       = req_b[16*g +: 16];
               mOp      = req_op[g];
               grants.push_back(g);
               grantCycle.push_back(cycle);
            end
         end else if (age == 1) begin
            expData = refY;
            age     = 2;
         end else if (resp_ready[gntM]) begin
            inFlight = 1'b0;
            count    = (count + 1) % (1 << CNT_W);
         end else begin
            age++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic setReq(input int i, input logic [15:0] a, input logic [15:0] b, input logic op);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_op[i]         = op;
   endtask

   task automatic resetPulse();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int base;
      int order [5];
      order = '{0, 1, 2, 3, 0};

      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Single add from requester 0: 1.0 + 1.0 = 2.0
      setReq(0, 16'h3C00, 16'h3C00, 1'b0);
      req_valid = 4'b0001;
      #1 check("t1_req_ready", req_ready, 4'b0001);
      tick(1);
      req_valid = '0;
      tick(1);
      check("t1_resp_valid", resp_valid, 4'b0001);
      check("t1_resp_data", resp_data, 16'h4000);
      resp_ready = 4'b0001;
      tick(1);
      check("t1_op_count", op_count, 1);
      check("t1_idle", busy, 0);
      resp_ready = '0;

      // Fairness: everyone valid, responses always accepted.
      resetPulse();
      for (int i = 0; i < NUM_REQ; i++) setReq(i, 16'($urandom), 16'($urandom), 1'($urandom));
      base       = grants.size();
      req_valid  = '1;
      resp_ready = '1;
      for (int n = 0; n < 40 && grants.size() < base + 5; n++) tick(1);
      req_valid = '0;
      check("fair_grant_count", grants.size() - base, 5);
      tick(3);
      check("fair_op_count", op_count, 5);
      if (grants.size() >= base + 5) begin
         for (int i = 0; i < 5; i++) begin
            check("fair_order", grants[base+i], order[i]);
            if (i > 0) check("fair_spacing", grantCycle[base+i] - grantCycle[base+i-1], 3);
         end
      end
      resp_ready = '0;

      // Held response: 2.0 - 1.0 = 1.0, requester 2 stalls for 5 cycles.
      setReq(2, 16'h4000, 16'h3C00, 1'b1);
      req_valid = 4'b0100;
      tick(1);
      req_valid = '0;
      tick(1);
      req_valid  = 4'b1011;
      resp_ready = 4'b1011;
      for (int n = 0; n < 5; n++) begin
         check("t3_resp_valid", resp_valid, 4'b0100);
         check("t3_resp_data", resp_data, 16'h3C00);
         check("t3_req_ready", req_ready, '0);
         tick(1);
      end
      resp_ready = 4'b0100;
      check("t3_busy_hold", busy, 1);
      tick(1);
      check("t3_idle", busy, 0);
      req_valid  = '0;
      resp_ready = '0;
      tick(1);

      // Reset while in EXEC aborts the transaction.
      setReq(1, 16'h3C00, 16'h0000, 1'b0);
      req_valid = 4'b0010;
      tick(1);
      req_valid = '0;
      check("t4_exec_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t4_async_busy", busy, 0);
      check("t4_async_resp_valid", resp_valid, '0);
      check("t4_async_req_ready", req_ready, '0);
      check("t4_async_resp_data", resp_data, '0);
      check("t4_async_op_count", op_count, '0);
      tick(1);
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tick(1);
         check("t4_no_resp", resp_valid, '0);
      end
      req_valid = 4'b0010;
      tick(1);
      req_valid = '0;
      tick(1);
      check("t4_resp_valid", resp_valid, 4'b0010);
      check("t4_resp_data", resp_data, 16'h3C00);
      resp_ready = 4'b0010;
      tick(1);
      resp_ready = '0;

      // Requester 3 withdraws just before its turn; requester 1 wins.
      base = grants.size();
      setReq(2, 16'h4200, 16'h3C00, 1'b0);
      req_valid = 4'b0100;
      tick(1);
      req_valid = 4'b1010;
      tick(1);
      resp_ready = 4'b0100;
      req_valid  = 4'b0010;
      tick(1);
      check("t5_req_ready", req_ready, 4'b0010);
      resp_ready = '1;
      tick(1);
      req_valid = '0;
      tick(2);
      check("t5_grant_count", grants.size() - base, 2);
      if (grants.size() >= base + 2) begin
         check("t5_first", grants[base], 2);
         check("t5_second", grants[base+1], 1);
      end
      check("t5_idle", busy, 0);

      // Counter wrap with CNT_W=4: 16 completions return it to zero.
      resetPulse();
      resp_ready = '1;
      for (int n = 0; n < 16; n++) begin
         setReq(0, 16'($urandom), 16'($urandom), 1'($urandom));
         req_valid = 4'b0001;
         tick(1);
         req_valid = '0;
         tick(2);
         if (n == 14) check("wrap_15", op_count, 15);
      end
      check("wrap_0", op_count, 0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NUM_REQ; i++) setReq(i, 16'($urandom), 16'($urandom), 1'($urandom));
         req_valid  = NUM_REQ'($urandom);
         resp_ready = NUM_REQ'($urandom);
         tick(1);
      end
      req_valid  = '0;
      resp_ready = '1;
      tick(5);
      check("final_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
